yutorina_rst_seq: RTL

- Reset/clock-lock sequencer that drives the Spartan-3E DCM reset and releases chip reset only after a verified, stable lock.
- Sits beside the clock generator: pulses the DCM reset for a fixed width and waits for LOCKED with a timeout.
- Retries the DCM a bounded number of times and latches an error if lock is never achieved.
- Re-asserts chip reset and restarts the sequence on any lock loss during operation.

---
 rtl/yutorina_rst_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/yutorina_rst_seq.sv
// DCM reset / lock sequencer: pulses DCM reset, qualifies LOCKED, then releases chip reset.
// Latency: LOCKED is seen 2 cycles after it changes (2-flop synchroniser); all outputs are registered.
// No flow control: free-running FSM, retries a bounded number of times, then latches lock_err.
module yutorina_rst_seq #(
  parameter int DCM_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int STABLE_CYCLES  = 16,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  output logic       dcm_rst,
  output logic       chip_rst,
  output logic       lock_err,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] S_DCM_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  localparam logic [CNT_W-1:0] DCM_LAST     = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             locked_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       state_nxt;
  logic [1:0]       retry_nxt;

  // Two-flop synchroniser for the DCM LOCKED output (asynchronous to clk).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
    end
  end

  // Next-state, counter and retry bookkeeping for the lock sequence.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    case (state)
      S_DCM_RST: begin
        if (cnt == DCM_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still wins.
        if (locked_s) begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_nxt = '0;
          if (32'(retry_cnt) < MAX_RETRY) begin
            retry_nxt = retry_cnt + 2'd1;
            state_nxt = S_DCM_RST;
          end else begin
            state_nxt = S_FAIL;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_STABLE: begin
        // Any captured drop restarts qualification with a fresh timeout.
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          retry_nxt = 2'd0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_nxt = S_DCM_RST;
          cnt_nxt   = '0;
        end
      end
      S_FAIL: begin
        // Terminal until reset; LOCKED is ignored here.
        state_nxt = S_FAIL;
      end
      default: begin
        state_nxt = S_DCM_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so they move with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_DCM_RST;
      cnt       <= '0;
      retry_cnt <= 2'd0;
      dcm_rst   <= 1'b1;
      chip_rst  <= 1'b1;
      lock_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      dcm_rst   <= (state_nxt == S_DCM_RST);
      chip_rst  <= (state_nxt != S_RUN);
      lock_err  <= (state_nxt == S_FAIL);
    end
  end

endmodule
